uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 155 +++++++++++++++
 tb/tb_uart_receiver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_receiver : oversampled UART receiver (mid-bit sampling, frame check)
// Revision 1.0
// ---------------------------------------------------------------------------
module uart_receiver #(
   parameter int clk_speed = 100_000000,
   parameter int baudrate  = 921600,
   parameter int D_BITS    = 8,
   parameter int SP_BITS   = 1
) (
   input  logic              i_clk,
   input  logic              reset,
   input  logic              i_rx,
   output logic [D_BITS-1:0] o_rx_data,
   output logic              o_rx_done,
   output logic              o_frame_err,
   output logic              o_rx_busy
);

   localparam int CPB  = clk_speed / baudrate;
   localparam int HALF = CPB / 2;
   localparam int CW   = (CPB > 1) ? $clog2(CPB) : 1;
   localparam int BW   = $clog2(D_BITS + 1);

   localparam logic [CW-1:0] C_BIT_END  = CW'(CPB - 1);
   localparam logic [CW-1:0] C_HALF_END = CW'(HALF - 1);
   localparam logic [BW-1:0] C_LAST_BIT = BW'(D_BITS - 1);
   localparam logic          C_LAST_SP  = 1'(SP_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   logic [1:0]        rst_sync_q;
   logic              rst_n_s;
   logic [1:0]        sync_q;
   logic              rx_s;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              stop_q, stop_d;
   logic              bad_q, bad_d;
   logic              arm_q, arm_d;
   logic [D_BITS-1:0] shift_q, shift_d;
   logic [D_BITS-1:0] data_q, data_d;
   logic              done_q, done_d;
   logic              ferr_q, ferr_d;
   logic              busy_q;

   // Reset asserts immediately but releases only on a clock edge.
   always_ff @(posedge i_clk or negedge reset) begin
      if (!reset) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n_s = rst_sync_q[1];

   always_ff @(posedge i_clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         sync_q  <= 2'b11;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         bad_q   <= 1'b0;
         arm_q   <= 1'b0;
         shift_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], i_rx};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         bad_q   <= bad_d;
         arm_q   <= arm_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
         busy_q  <= (state_d != IDLE);
      end
   end
   assign rx_s = sync_q[1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      bit_d   = bit_q;
      stop_d  = stop_q;
      bad_d   = bad_q;
      arm_d   = arm_q;
      shift_d = shift_q;
      data_d  = data_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            bit_d  = '0;
            stop_d = 1'b0;
            bad_d  = 1'b0;
            // arm_q blocks a stuck-low line from retriggering after a frame error
            if (rx_s)       arm_d   = 1'b1;
            else if (arm_q) state_d = START;
         end
         START: begin
            if (cnt_q == C_HALF_END) begin
               cnt_d   = '0;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt_q == C_BIT_END) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[D_BITS-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == C_LAST_BIT) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == C_BIT_END) begin
               cnt_d  = '0;
               stop_d = stop_q + 1'b1;
               bad_d  = bad_q | ~rx_s;
               if (stop_q == C_LAST_SP) begin
                  state_d = IDLE;
                  if (bad_q || !rx_s) begin
                     ferr_d = 1'b1;
                     arm_d  = 1'b0;
                  end else begin
                     done_d = 1'b1;
                     data_d = shift_q;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign o_rx_data   = data_q;
   assign o_rx_done   = done_q;
   assign o_frame_err = ferr_q;
   assign o_rx_busy   = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_receiver : directed + random frames against a bit-level frame model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_uart_receiver;

   localparam int CPB = 100_000000 / 921600;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_a = 1'b1;
   logic       rx_b = 1'b1;
   logic [7:0] data_a;
   logic [6:0] data_b;
   logic       done_a, ferr_a, busy_a;
   logic       done_b, ferr_b, busy_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_receiver dut_a (
      .i_clk(clk), .reset(reset), .i_rx(rx_a),
      .o_rx_data(data_a), .o_rx_done(done_a), .o_frame_err(ferr_a), .o_rx_busy(busy_a)
   );

   uart_receiver #(.D_BITS(7), .SP_BITS(2)) dut_b (
      .i_clk(clk), .reset(reset), .i_rx(rx_b),
      .o_rx_data(data_b), .o_rx_done(done_b), .o_frame_err(ferr_b), .o_rx_busy(busy_b)
   );

   // Event monitor: pulse counts, pulse widths, captured words and times.
   int         cyc = 0;
   int         done_a_n = 0, ferr_a_n = 0, busy_a_n = 0, viol_a = 0;
   int         done_b_n = 0, ferr_b_n = 0, viol_b = 0;
   logic       done_a_p = 1'b0, ferr_a_p = 1'b0, done_b_p = 1'b0, ferr_b_p = 1'b0;
   logic [7:0] da [0:63];
   int         ta [0:63];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (done_a) begin
         if (done_a_n < 64) begin
            da[done_a_n] <= data_a;
            ta[done_a_n] <= cyc;
         end
         done_a_n <= done_a_n + 1;
      end
      if (ferr_a) ferr_a_n <= ferr_a_n + 1;
      if (busy_a) busy_a_n <= busy_a_n + 1;
      if ((done_a && (done_a_p || ferr_a)) || (ferr_a && ferr_a_p)) viol_a <= viol_a + 1;
      if (done_b) done_b_n <= done_b_n + 1;
      if (ferr_b) ferr_b_n <= ferr_b_n + 1;
      if ((done_b && (done_b_p || ferr_b)) || (ferr_b && ferr_b_p)) viol_b <= viol_b + 1;
      done_a_p <= done_a;
      ferr_a_p <= ferr_a;
      done_b_p <= done_b;
      ferr_b_p <= ferr_b;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_rx(input bit which, input logic v);
      if (which) rx_b = v;
      else       rx_a = v;
   endtask

   // Serial frame: start bit, nd data bits LSB first, ns stop bits from stp.
   task automatic send_frame(input bit which, input logic [8:0] d, input int nd,
                             input logic [1:0] stp, input int ns);
      set_rx(which, 1'b0);
      wait_cyc(CPB);
      for (int i = 0; i < nd; i++) begin
         set_rx(which, d[i]);
         wait_cyc(CPB);
      end
      for (int i = 0; i < ns; i++) begin
         set_rx(which, stp[i]);
         wait_cyc(CPB);
      end
      set_rx(which, 1'b1);
   endtask

   int         d0, f0, b0, n_exp, n_ferr;
   logic [7:0] exp_last;
   logic [7:0] exp_q [$];
   logic [7:0] rb;
   bit         good;
   int         gap;

   initial begin
      // Reset state
      wait_cyc(5);
      check("reset_data", {24'd0, data_a}, 32'h0);
      check("reset_done", {31'd0, done_a}, 32'h0);
      check("reset_ferr", {31'd0, ferr_a}, 32'h0);
      check("reset_busy", {31'd0, busy_a}, 32'h0);
      check("reset_data_b", {25'd0, data_b}, 32'h0);
      reset = 1'b1;
      wait_cyc(20);

      // Single valid frame 0xA5
      d0 = done_a_n; f0 = ferr_a_n;
      send_frame(1'b0, 9'h0A5, 8, 2'b11, 1);
      wait_cyc(30);
      check("a5_done_cnt", done_a_n - d0, 1);
      check("a5_ferr_cnt", ferr_a_n - f0, 0);
      check("a5_data", {24'd0, data_a}, 32'hA5);
      check("a5_captured", {24'd0, da[d0]}, 32'hA5);

      // Short low glitch: rejected at the start-bit midpoint
      d0 = done_a_n; f0 = ferr_a_n; b0 = busy_a_n;
      rx_a = 1'b0;
      wait_cyc(30);
      rx_a = 1'b1;
      wait_cyc(200);
      check("glitch_done_cnt", done_a_n - d0, 0);
      check("glitch_ferr_cnt", ferr_a_n - f0, 0);
      check("glitch_busy_len", {31'd0, (busy_a_n - b0 >= 50) && (busy_a_n - b0 <= 58)}, 32'h1);
      check("glitch_busy_end", {31'd0, busy_a}, 32'h0);

      // Valid 0x3C, then 0x81 with a low stop bit
      d0 = done_a_n; f0 = ferr_a_n;
      send_frame(1'b0, 9'h03C, 8, 2'b11, 1);
      wait_cyc(20);
      send_frame(1'b0, 9'h081, 8, 2'b00, 1);
      wait_cyc(30);
      check("ferr_done_cnt", done_a_n - d0, 1);
      check("ferr_ferr_cnt", ferr_a_n - f0, 1);
      check("ferr_data_held", {24'd0, data_a}, 32'h3C);

      // Back-to-back 0x00 and 0xFF, no idle gap
      d0 = done_a_n;
      send_frame(1'b0, 9'h000, 8, 2'b11, 1);
      send_frame(1'b0, 9'h0FF, 8, 2'b11, 1);
      wait_cyc(30);
      check("b2b_done_cnt", done_a_n - d0, 2);
      check("b2b_first", {24'd0, da[d0]}, 32'h00);
      check("b2b_second", {24'd0, da[d0+1]}, 32'hFF);
      check("b2b_spacing", ta[d0+1] - ta[d0], 10 * CPB);

      // Reset during data bit 4 of 0x5A, then 0x77
      d0 = done_a_n; f0 = ferr_a_n;
      rx_a = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 4; i++) begin
         rx_a = (8'h5A >> i) & 1;
         wait_cyc(CPB);
      end
      rx_a = 1'b1;
      wait_cyc(50);
      reset = 1'b0;
      wait_cyc(3);
      check("midrst_busy", {31'd0, busy_a}, 32'h0);
      check("midrst_data", {24'd0, data_a}, 32'h0);
      wait_cyc(10);
      reset = 1'b1;
      wait_cyc(CPB * 8);
      send_frame(1'b0, 9'h077, 8, 2'b11, 1);
      wait_cyc(30);
      check("midrst_done_cnt", done_a_n - d0, 1);
      check("midrst_ferr_cnt", ferr_a_n - f0, 0);
      check("midrst_new_data", {24'd0, data_a}, 32'h77);

      // Random frames against the frame-level model
      d0 = done_a_n; f0 = ferr_a_n;
      n_exp = 0; n_ferr = 0; exp_last = data_a;
      exp_q.delete();
      for (int k = 0; k < 14; k++) begin
         rb   = 8'($urandom);
         good = ($urandom_range(0, 3) != 0);
         send_frame(1'b0, {1'b0, rb}, 8, {1'b1, good}, 1);
         if (good) begin
            exp_q.push_back(rb);
            exp_last = rb;
            n_exp++;
         end else begin
            n_ferr++;
         end
         gap = good ? $urandom_range(0, 40) : $urandom_range(10, 40);
         wait_cyc(gap);
      end
      wait_cyc(CPB * 2);
      check("rand_done_cnt", done_a_n - d0, n_exp);
      check("rand_ferr_cnt", ferr_a_n - f0, n_ferr);
      check("rand_last_data", {24'd0, data_a}, {24'd0, exp_last});
      foreach (exp_q[k]) check("rand_word", {24'd0, da[d0 + k]}, {24'd0, exp_q[k]});
      check("a_pulse_rules", viol_a, 0);

      // 7 data bits, 2 stop bits
      d0 = done_b_n; f0 = ferr_b_n;
      send_frame(1'b1, 9'h055, 7, 2'b01, 2);
      wait_cyc(30);
      check("b_stop2_ferr", ferr_b_n - f0, 1);
      check("b_stop2_done", done_b_n - d0, 0);
      check("b_stop2_data", {25'd0, data_b}, 32'h0);
      send_frame(1'b1, 9'h02A, 7, 2'b10, 2);
      wait_cyc(30);
      check("b_stop1_ferr", ferr_b_n - f0, 2);
      send_frame(1'b1, 9'h055, 7, 2'b11, 2);
      wait_cyc(30);
      check("b_good_done", done_b_n - d0, 1);
      check("b_good_data", {25'd0, data_b}, 32'h55);
      check("b_pulse_rules", viol_b, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
